// File: rtl/dphy_lane_hs_tx.sv
// dphy_lane_hs_tx
//   Per-lane D-PHY HS transmit sequencer. It takes a byte stream from the DSI
//   packet layer and walks the lane through a complete burst:
//   LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync (0xB8) -> payload -> trailer
//   -> LP-11 exit -> idle. Everything runs in the SerDes word clock domain.
//
// Ports
//   clk_i       word clock (same clock as the SerDes word input)
//   rst_n_i     synchronous reset, active low
//   data_i      payload byte
//   valid_i     byte valid; in IDLE this also requests a burst
//   last_i      marks the final byte of the burst
//   ready_o     byte accepted when valid_i && ready_o
//   d_o         8-bit HS word to the SerDes
//   serdes_t_o  HS tristate to SerDes; 1 = HS driver off
//   lp_p_o      LP level, P line
//   lp_n_o      LP level, N line
//   lp_oe_o     LP drivers enabled
//   busy_o      burst in progress
//   underrun_o  one-cycle pulse when the payload source runs dry
module dphy_lane_hs_tx #(
    parameter int g_lpx_cycles     = 4,
    parameter int g_prepare_cycles = 3,
    parameter int g_zero_words     = 6,
    parameter int g_trail_words    = 4,
    parameter int g_exit_cycles    = 6
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    input  logic       last_i,
    output logic       ready_o,
    output logic [7:0] d_o,
    output logic       serdes_t_o,
    output logic       lp_p_o,
    output logic       lp_n_o,
    output logic       lp_oe_o,
    output logic       busy_o,
    output logic       underrun_o
);

    typedef enum logic [2:0] {
        IDLE, LPRQ, PREP, ZERO, SYNC, PAYLOAD, TRAIL, EXIT
    } state_t;

    localparam logic [7:0] SYNC_WORD = 8'hB8;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       last_bit_q, last_bit_d;
    logic       accept;

    // next-cycle values of the registered outputs
    logic [7:0] d_d;
    logic       t_d, lpp_d, lpn_d, oe_d, rdy_d, busy_d, und_d;

    // ready_o is the registered decode of SYNC/PAYLOAD, so it tracks state_q
    assign accept = ready_o && valid_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
        und_d      = 1'b0;
        last_bit_d = last_bit_q;

        case (state_q)
            IDLE: if (valid_i) begin
                state_d = LPRQ;
                cnt_d   = 8'(g_lpx_cycles - 1);
            end
            LPRQ: if (cnt_q == 8'd0) begin
                state_d = PREP;
                cnt_d   = 8'(g_prepare_cycles - 1);
            end
            PREP: if (cnt_q == 8'd0) begin
                state_d = ZERO;
                cnt_d   = 8'(g_zero_words - 1);
            end
            ZERO: if (cnt_q == 8'd0) begin
                state_d    = SYNC;
                // with no payload the trailer inverts bit 7 of the sync word
                last_bit_d = SYNC_WORD[7];
            end
            SYNC, PAYLOAD: begin
                if (!valid_i) begin
                    state_d = TRAIL;
                    cnt_d   = 8'(g_trail_words - 1);
                    und_d   = 1'b1;
                end else begin
                    last_bit_d = data_i[7];
                    if (last_i) begin
                        // one extra TRAIL cycle: the last byte is still on d_o
                        state_d = TRAIL;
                        cnt_d   = 8'(g_trail_words);
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            TRAIL: if (cnt_q == 8'd0) begin
                state_d = EXIT;
                cnt_d   = 8'(g_exit_cycles - 1);
            end
            EXIT: if (cnt_q == 8'd0) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs decoded from the next state, so they land in the
    // registers on the same edge as the state they describe.
    always_comb begin
        d_d    = 8'h00;
        t_d    = 1'b1;
        lpp_d  = 1'b1;
        lpn_d  = 1'b1;
        oe_d   = 1'b1;
        rdy_d  = 1'b0;
        busy_d = (state_d != IDLE);

        case (state_d)
            LPRQ: lpp_d = 1'b0;
            PREP: begin
                lpp_d = 1'b0;
                lpn_d = 1'b0;
            end
            ZERO, SYNC, PAYLOAD, TRAIL: begin
                lpp_d = 1'b0;
                lpn_d = 1'b0;
                oe_d  = 1'b0;
                t_d   = 1'b0;
                rdy_d = (state_d == SYNC) || (state_d == PAYLOAD);
                if (state_d == SYNC)
                    d_d = SYNC_WORD;
                else if (accept)
                    d_d = data_i;
                else if (state_d == TRAIL)
                    d_d = {8{~last_bit_q}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            last_bit_q <= 1'b1;
            d_o        <= 8'h00;
            serdes_t_o <= 1'b1;
            lp_p_o     <= 1'b1;
            lp_n_o     <= 1'b1;
            lp_oe_o    <= 1'b1;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_bit_q <= last_bit_d;
            d_o        <= d_d;
            serdes_t_o <= t_d;
            lp_p_o     <= lpp_d;
            lp_n_o     <= lpn_d;
            lp_oe_o    <= oe_d;
            ready_o    <= rdy_d;
            busy_o     <= busy_d;
            underrun_o <= und_d;
        end
    end

endmodule
